// File: rtl/chan_coinc_detect_if.sv
// chan_coinc_detect_if
//   Bundles the sample/control inputs and the history/event outputs of the
//   coincidence detector so the block connects through one port.
//   Parameters must match those of the chan_coinc_detect instance it serves.
//   master : drives en, in_ch, mode, clr; observes hist, cls, coinc,
//            coinc_cnt, cnt_sat
//   slave  : the detector side (mirror of master)
interface chan_coinc_detect_if #(
  parameter int N_CH  = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) ();

  logic                    en;
  logic [N_CH-1:0]         in_ch;
  logic [1:0]              mode;
  logic                    clr;
  logic [N_CH*DEPTH-1:0]   hist;
  logic [2*N_CH-1:0]       cls;
  logic                    coinc;
  logic [CNT_W-1:0]        coinc_cnt;
  logic                    cnt_sat;

  modport master (
    output en, in_ch, mode, clr,
    input  hist, cls, coinc, coinc_cnt, cnt_sat
  );

  modport slave (
    input  en, in_ch, mode, clr,
    output hist, cls, coinc, coinc_cnt, cnt_sat
  );

endinterface

// File: rtl/chan_coinc_detect.sv
// chan_coinc_detect
//   N-channel history / coincidence detector. Each channel shifts its input
//   into a DEPTH-deep history on enabled cycles; each history is classified
//   (empty / seen-but-not-full-age / oldest sample set), and a one-cycle
//   coincidence pulse is raised one cycle after each sample when the channels
//   coincide under the selected mode. A saturating pulse counter with a
//   sticky saturation flag is kept.
// Ports
//   clk  : system clock, rising edge
//   arst : asynchronous reset, active-high
//   bus  : chan_coinc_detect_if.slave
//          en        sample enable (shift all histories)
//          in_ch     channel inputs, bit i = channel i
//          mode      0 LEVEL (all stable), 1 EDGE (all rising),
//                    2 ANY (>=2 active), 3 OFF
//          clr       synchronous clear of coinc_cnt / cnt_sat
//          hist      histories, hist[i*DEPTH +: DEPTH] = channel i, bit 0 newest
//          cls       per-channel class, cls[2i +: 2] = channel i
//          coinc     coincidence pulse
//          coinc_cnt saturating count of coinc pulses
//          cnt_sat   sticky: coinc_cnt reached all-ones
module chan_coinc_detect #(
  parameter int N_CH  = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                arst,
  chan_coinc_detect_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'd0,
    MODE_EDGE  = 2'd1,
    MODE_ANY   = 2'd2,
    MODE_OFF   = 2'd3
  } mode_e;

  localparam int ACT_W = $clog2(N_CH + 1);

  logic [N_CH-1:0][DEPTH-1:0] hist_q;
  logic [N_CH-1:0][1:0]       cls_q;
  logic [N_CH-1:0][1:0]       cls_d;
  logic [N_CH-1:0]            stable;
  logic [N_CH-1:0]            rise;
  logic [N_CH-1:0]            act;
  logic [ACT_W-1:0]           act_cnt;
  logic                       cond;
  logic                       en_d_q;
  logic                       coinc_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_d;
  logic                       sat_q;
  logic                       sat_d;
  mode_e                      mode;

  assign mode = mode_e'(bus.mode);

  // History shift registers; only en moves them, clr leaves them alone.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      hist_q <= '0;
    end else if (bus.en) begin
      for (int i = 0; i < N_CH; i++) begin
        hist_q[i] <= {hist_q[i][DEPTH-2:0], bus.in_ch[i]};
      end
    end
  end

  // Per-channel terms, all taken from the current (already registered)
  // history so evaluation sees the sample shifted in at the previous edge.
  always_comb begin
    stable = '0;
    rise   = '0;
    act    = '0;
    cls_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      stable[i] = &hist_q[i];
      rise[i]   = (hist_q[i][1:0] == 2'b01);
      act[i]    = hist_q[i][0];
      if (hist_q[i] == '0) begin
        cls_d[i] = 2'b00;
      end else if (hist_q[i][DEPTH-1]) begin
        cls_d[i] = 2'b11;
      end else begin
        cls_d[i] = 2'b01;
      end
    end
  end

  always_comb begin
    act_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      act_cnt = act_cnt + ACT_W'(act[i]);
    end
  end

  always_comb begin
    cond = 1'b0;
    case (mode)
      MODE_LEVEL: cond = &stable;
      MODE_EDGE:  cond = &rise;
      MODE_ANY:   cond = (act_cnt >= ACT_W'(2));
      MODE_OFF:   cond = 1'b0;
      default:    cond = 1'b0;
    endcase
  end

  // en_d gates evaluation to the cycle right after a sample, which keeps
  // coinc to at most one pulse per sample even if en stays high.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cls_q   <= '0;
      en_d_q  <= 1'b0;
      coinc_q <= 1'b0;
    end else begin
      cls_q   <= cls_d;
      en_d_q  <= bus.en;
      coinc_q <= en_d_q & cond;
    end
  end

  // Counter next state: clr wins over an increment in the same cycle;
  // the flag is set as the count lands on all-ones and stays until clr.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (bus.clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (coinc_q && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_d == '1) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign bus.hist      = hist_q;
  assign bus.cls       = cls_q;
  assign bus.coinc     = coinc_q;
  assign bus.coinc_cnt = cnt_q;
  assign bus.cnt_sat   = sat_q;

endmodule

// File: tb/tb_chan_coinc_detect.sv
// tb_chan_coinc_detect
//   Directed bench for chan_coinc_detect with N_CH=4, DEPTH=4, CNT_W=2.
//   Each scenario task drives samples and compares outputs one time unit
//   after the active clock edge.
module tb_chan_coinc_detect;

  logic clk;
  logic arst;
  int   compared;
  int   mismatched;

  chan_coinc_detect_if #(.N_CH(4), .DEPTH(4), .CNT_W(2)) bus ();

  chan_coinc_detect #(.N_CH(4), .DEPTH(4), .CNT_W(2)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample and step to just after the edge that takes it.
  task automatic sample(input logic e, input logic [3:0] d);
    bus.en    = e;
    bus.in_ch = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst      = 1'b1;
    bus.en    = 1'b0;
    bus.in_ch = 4'h0;
    bus.mode  = 2'd0;
    bus.clr   = 1'b0;
    #1;
    compared++;
    if (bus.hist !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL reset_hist got %h want 0000", bus.hist);
    end
    compared++;
    if (bus.cls !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_cls got %h want 00", bus.cls);
    end
    compared++;
    if ({bus.coinc, bus.coinc_cnt, bus.cnt_sat} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_evt got coinc=%b cnt=%0d sat=%b want all 0",
               bus.coinc, bus.coinc_cnt, bus.cnt_sat);
    end
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_level();
    bus.mode = 2'd0;
    for (int i = 0; i < 4; i++) sample(1'b1, 4'hF);
    compared++;
    if (bus.coinc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL level_early got %b want 0", bus.coinc);
    end
    compared++;
    if (bus.hist !== 16'hFFFF) begin
      mismatched++;
      $display("[TB] FAIL level_hist got %h want FFFF", bus.hist);
    end
    sample(1'b0, 4'h0);
    compared++;
    if (bus.coinc !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL level_pulse got %b want 1", bus.coinc);
    end
    compared++;
    if (bus.cls !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL level_cls got %h want FF", bus.cls);
    end
    sample(1'b1, 4'hF);
    compared++;
    if (bus.coinc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL level_width got %b want 0", bus.coinc);
    end
    sample(1'b0, 4'h0);
    compared++;
    if (bus.coinc !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL level_5th got %b want 1", bus.coinc);
    end
    sample(1'b0, 4'h0);
    compared++;
    if (bus.coinc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL level_no_en got %b want 0", bus.coinc);
    end
  endtask

  task automatic test_async_reset();
    #2;
    arst = 1'b1;
    #1;
    compared++;
    if (bus.hist !== 16'h0000 || bus.cls !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL async_hist got hist=%h cls=%h want 0000/00", bus.hist, bus.cls);
    end
    compared++;
    if ({bus.coinc, bus.coinc_cnt, bus.cnt_sat} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL async_evt got coinc=%b cnt=%0d sat=%b want all 0",
               bus.coinc, bus.coinc_cnt, bus.cnt_sat);
    end
    #2;
    arst = 1'b0;
    sample(1'b1, 4'hF);
    compared++;
    if (bus.hist !== 16'h1111) begin
      mismatched++;
      $display("[TB] FAIL async_first got %h want 1111", bus.hist);
    end
  endtask

  task automatic test_edge();
    bus.mode = 2'd1;
    for (int i = 0; i < 4; i++) sample(1'b1, 4'h0);
    sample(1'b1, 4'h0);
    sample(1'b1, 4'h0);
    sample(1'b1, 4'hF);
    compared++;
    if (bus.coinc !== 1'b0 || bus.cls !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL edge_pre got coinc=%b cls=%h want 0/00", bus.coinc, bus.cls);
    end
    sample(1'b1, 4'hF);
    compared++;
    if (bus.coinc !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL edge_pulse got %b want 1", bus.coinc);
    end
    compared++;
    if (bus.cls !== 8'h55) begin
      mismatched++;
      $display("[TB] FAIL edge_cls01 got %h want 55", bus.cls);
    end
    sample(1'b1, 4'hF);
    compared++;
    if (bus.coinc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL edge_held got %b want 0", bus.coinc);
    end
    sample(1'b1, 4'hF);
    sample(1'b0, 4'h0);
    compared++;
    if (bus.cls !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL edge_cls11 got %h want FF", bus.cls);
    end
    for (int i = 0; i < 4; i++) sample(1'b1, 4'h0);
    sample(1'b1, 4'h7);
    sample(1'b0, 4'h0);
    compared++;
    if (bus.coinc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL edge_partial got %b want 0", bus.coinc);
    end
  endtask

  task automatic test_any();
    bus.mode = 2'd2;
    sample(1'b1, 4'h1);
    sample(1'b0, 4'h0);
    compared++;
    if (bus.coinc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL any_one got %b want 0", bus.coinc);
    end
    sample(1'b1, 4'h5);
    sample(1'b0, 4'h0);
    compared++;
    if (bus.coinc !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL any_two got %b want 1", bus.coinc);
    end
    bus.mode = 2'd3;
    sample(1'b1, 4'hF);
    sample(1'b0, 4'h0);
    compared++;
    if (bus.coinc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL off_mode got %b want 0", bus.coinc);
    end
    sample(1'b1, 4'hF);
    bus.mode = 2'd2;
    sample(1'b0, 4'h0);
    compared++;
    if (bus.coinc !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mode_switch got %b want 1", bus.coinc);
    end
  endtask

  task automatic test_counter();
    bus.mode = 2'd3;
    for (int i = 0; i < 4; i++) sample(1'b1, 4'hF);
    bus.clr = 1'b1;
    sample(1'b0, 4'h0);
    bus.clr = 1'b0;
    compared++;
    if (bus.coinc_cnt !== 2'd0 || bus.cnt_sat !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL cnt_clr0 got cnt=%0d sat=%b want 0/0", bus.coinc_cnt, bus.cnt_sat);
    end
    bus.mode = 2'd0;
    sample(1'b1, 4'hF);
    sample(1'b0, 4'h0);
    sample(1'b1, 4'hF);
    compared++;
    if (bus.coinc_cnt !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL cnt_one got %0d want 1", bus.coinc_cnt);
    end
    sample(1'b0, 4'h0);
    sample(1'b1, 4'hF);
    sample(1'b0, 4'h0);
    sample(1'b0, 4'h0);
    compared++;
    if (bus.coinc_cnt !== 2'd3 || bus.cnt_sat !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL cnt_sat got cnt=%0d sat=%b want 3/1", bus.coinc_cnt, bus.cnt_sat);
    end
    sample(1'b1, 4'hF);
    sample(1'b0, 4'h0);
    sample(1'b0, 4'h0);
    compared++;
    if (bus.coinc_cnt !== 2'd3 || bus.cnt_sat !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL cnt_hold got cnt=%0d sat=%b want 3/1", bus.coinc_cnt, bus.cnt_sat);
    end
    sample(1'b1, 4'hF);
    bus.clr = 1'b1;
    sample(1'b0, 4'h0);
    compared++;
    if (bus.coinc !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL clr_coinc got %b want 1", bus.coinc);
    end
    sample(1'b0, 4'h0);
    bus.clr = 1'b0;
    compared++;
    if (bus.coinc_cnt !== 2'd0 || bus.cnt_sat !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL clr_prio got cnt=%0d sat=%b want 0/0", bus.coinc_cnt, bus.cnt_sat);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic want;
    pulses   = 0;
    bus.mode = 2'd0;
    for (int i = 0; i < 8; i++) begin
      sample((i % 2) == 0, 4'hF);
      want = ((i % 2) == 1);
      if (bus.coinc === 1'b1) pulses++;
      compared++;
      if (bus.coinc !== want) begin
        mismatched++;
        $display("[TB] FAIL toggle_%0d got %b want %b", i, bus.coinc, want);
      end
    end
    compared++;
    if (pulses !== 4) begin
      mismatched++;
      $display("[TB] FAIL toggle_count got %0d want 4", pulses);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_level();
    test_async_reset();
    test_edge();
    test_any();
    test_counter();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
